// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants: FSM encodings, the zero register
// and default latencies used by the hazard sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MD_LATENCY_DEF  = 8;
  localparam int unsigned MEM_TIMEOUT_DEF = 64;

  // $0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_md_seq.sv
// Mul/div latency tracker: start in cycle T yields a one-cycle wb strobe in
// cycle T+MD_LATENCY; busy covers the whole in-flight window including wb.
module hazard_md_seq
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic wb
);

  localparam int unsigned CntW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MD_LATENCY - 2);

  md_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = CntLoad;
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != MD_IDLE);
    wb   = (state_q == MD_DONE);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/freeze sequencer: ID hazard detection, mul/div tracking,
// data-memory ack wait with timeout, and a saturating stall-cycle counter.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MD_LATENCY  = MD_LATENCY_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_branch_taken,
  input  logic             id_md_op,
  input  logic             id_uses_hilo,
  input  logic             exe_MemRead,
  input  logic             exe_RegWrite,
  input  logic [4:0]       exe_dest,
  input  logic             mem_MemRead,
  input  logic [4:0]       mem_dest,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic             pipe_freeze,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_wb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  logic lu, br, mdh, stall, freeze, timeout;
  logic exe_hit, mem_hit;
  logic md_busy_int, md_wb_int;

  mem_state_t       mem_state_q, mem_state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q;

  // Hazard terms
  always_comb begin
    exe_hit = (id_uses_rs && reg_match(id_rs, exe_dest)) ||
              (id_uses_rt && reg_match(id_rt, exe_dest));
    mem_hit = (id_uses_rs && reg_match(id_rs, mem_dest)) ||
              (id_uses_rt && reg_match(id_rt, mem_dest));
    lu      = exe_MemRead && exe_hit;
    br      = id_branch && ((exe_RegWrite && exe_hit) || (mem_MemRead && mem_hit));
    mdh     = (id_md_op || id_uses_hilo) && md_busy_int;
    stall   = lu || br || mdh;
  end

  // Memory-wait FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_state_q <= M_IDLE;
      wait_cnt_q  <= '0;
    end else begin
      mem_state_q <= mem_state_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    mem_state_d = mem_state_q;
    wait_cnt_d  = wait_cnt_q;
    unique case (mem_state_q)
      M_IDLE: begin
        if (dmem_req && !dmem_ack) begin
          mem_state_d = M_WAIT;
          wait_cnt_d  = '0;
        end
      end
      M_WAIT: begin
        if (dmem_ack || timeout) mem_state_d = M_IDLE;
        else                     wait_cnt_d  = wait_cnt_q + 1'b1;
      end
      default: mem_state_d = M_IDLE;
    endcase
  end

  // The timeout cycle itself releases the freeze.
  always_comb begin
    timeout = (mem_state_q == M_WAIT) && !dmem_ack && (wait_cnt_q == WaitLast);
    if (mem_state_q == M_IDLE) freeze = dmem_req && !dmem_ack;
    else                       freeze = !dmem_ack && !timeout;
  end

  hazard_md_seq #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_seq (
    .clk  (clk),
    .rst  (rst),
    .start(md_start),
    .busy (md_busy_int),
    .wb   (md_wb_int)
  );

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    pipe_freeze   = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_bubble = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (stall) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_exe_bubble = 1'b1;
    end else begin
      if_id_flush = id_branch && id_branch_taken;
    end
    md_start = id_md_op && !freeze && !stall && !rst;
    md_busy  = md_busy_int;
    md_wb    = md_wb_int;
    mem_err  = timeout && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (!pc_write && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a vector table of one-cycle rows fed
// through a scoreboard queue, plus hand-driven reset sequences.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ctl bits: urs urt br bt mdop hilo emr erw
  localparam logic [7:0] C_URS = 8'h80, C_URT = 8'h40, C_BR = 8'h20, C_BT = 8'h10;
  localparam logic [7:0] C_MD = 8'h08, C_HL = 8'h04, C_EMR = 8'h02, C_ERW = 8'h01;
  // mem bits: mem_MemRead dmem_req dmem_ack
  localparam logic [2:0] M_MMR = 3'b100, M_REQ = 3'b010, M_ACK = 3'b001;
  // obs bits: pc_write if_id_write if_id_flush bubble freeze md_start md_busy md_wb mem_err
  localparam logic [8:0] RUN = 9'h180, STL = 9'h020, FRZ = 9'h010, FLS = 9'h1C0;
  localparam logic [8:0] START = 9'h008, BUSY = 9'h004, WB = 9'h002, ERR = 9'h001;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [7:0] ctl;
    logic [4:0] ed;
    logic [4:0] md;
    logic [2:0] mem;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, exe_dest, mem_dest;
  logic id_uses_rs, id_uses_rt, id_branch, id_branch_taken, id_md_op, id_uses_hilo;
  logic exe_MemRead, exe_RegWrite, mem_MemRead, dmem_req, dmem_ack;
  logic pc_write, if_id_write, if_id_flush, id_exe_bubble, pipe_freeze;
  logic md_start, md_busy, md_wb, mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [8:0] obs;

  int checks = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic [8:0] exp_q[$];
  logic [CNT_W-1:0] cnt_q[$];
  vec_t tbl[$];

  hazard_ctrl #(
    .MD_LATENCY (8),
    .MEM_TIMEOUT(4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_branch      (id_branch),
    .id_branch_taken(id_branch_taken),
    .id_md_op       (id_md_op),
    .id_uses_hilo   (id_uses_hilo),
    .exe_MemRead    (exe_MemRead),
    .exe_RegWrite   (exe_RegWrite),
    .exe_dest       (exe_dest),
    .mem_MemRead    (mem_MemRead),
    .mem_dest       (mem_dest),
    .dmem_req       (dmem_req),
    .dmem_ack       (dmem_ack),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_exe_bubble  (id_exe_bubble),
    .pipe_freeze    (pipe_freeze),
    .md_start       (md_start),
    .md_busy        (md_busy),
    .md_wb          (md_wb),
    .mem_err        (mem_err),
    .stall_cycles   (stall_cycles)
  );

  assign obs = {pc_write, if_id_write, if_id_flush, id_exe_bubble, pipe_freeze,
                md_start, md_busy, md_wb, mem_err};

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [7:0] ctl,
                              input logic [4:0] ed, input logic [4:0] md, input logic [2:0] mem,
                              input logic [8:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.ctl = ctl; v.ed = ed; v.md = md; v.mem = mem; v.exp = exp;
    return v;
  endfunction

  function automatic vec_t nop(input logic [2:0] mem, input logic [7:0] ctl,
                               input logic [8:0] exp);
    return mk(5'd0, 5'd0, ctl, 5'd0, 5'd0, mem, exp);
  endfunction

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; exe_dest = v.ed; mem_dest = v.md;
    {id_uses_rs, id_uses_rt, id_branch, id_branch_taken} = v.ctl[7:4];
    {id_md_op, id_uses_hilo, exe_MemRead, exe_RegWrite} = v.ctl[3:0];
    {mem_MemRead, dmem_req, dmem_ack} = v.mem;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One cycle: drive, queue expectations, compare at negedge, advance model at posedge.
  task automatic step(input vec_t v, input int idx);
    logic [8:0] eo;
    logic [CNT_W-1:0] ec;
    drive(v);
    exp_q.push_back(v.exp);
    cnt_q.push_back(exp_cnt);
    @(negedge clk);
    eo = exp_q.pop_front();
    ec = cnt_q.pop_front();
    cmp($sformatf("vec%0d_outputs", idx), 32'(obs), 32'(eo));
    cmp($sformatf("vec%0d_stall_cycles", idx), 32'(stall_cycles), 32'(ec));
    @(posedge clk);
    if (!v.exp[8] && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Load-use on rs / rt, unused operand, zero register.
    tbl.push_back(mk(5'd8, 5'd0, C_URS | C_EMR | C_ERW, 5'd8, 5'd0, 3'b000, STL));
    tbl.push_back(mk(5'd8, 5'd0, C_URS, 5'd0, 5'd8, M_MMR, RUN));
    tbl.push_back(mk(5'd0, 5'd9, C_URT | C_EMR | C_ERW, 5'd9, 5'd0, 3'b000, STL));
    tbl.push_back(mk(5'd9, 5'd0, C_URT | C_EMR | C_ERW, 5'd9, 5'd0, 3'b000, RUN));
    tbl.push_back(mk(5'd0, 5'd0, C_URS | C_URT | C_EMR | C_ERW, 5'd0, 5'd0, 3'b000, RUN));
    // Load feeding a taken branch: stall via EX, then via MEM, then flush once.
    tbl.push_back(mk(5'd8, 5'd0, C_URS | C_BR | C_BT | C_EMR | C_ERW, 5'd8, 5'd0, 3'b000, STL));
    tbl.push_back(mk(5'd8, 5'd0, C_URS | C_BR | C_BT, 5'd0, 5'd8, M_MMR, STL));
    tbl.push_back(mk(5'd8, 5'd0, C_URS | C_BR | C_BT, 5'd0, 5'd0, 3'b000, FLS));
    tbl.push_back(nop(3'b000, 8'h00, RUN));
    // ALU result feeding branch; MEM non-load does not stall; not-taken no flush.
    tbl.push_back(mk(5'd0, 5'd5, C_URT | C_BR | C_BT | C_ERW, 5'd5, 5'd0, 3'b000, STL));
    tbl.push_back(mk(5'd0, 5'd5, C_URT | C_BR | C_BT, 5'd0, 5'd5, 3'b000, FLS));
    tbl.push_back(mk(5'd3, 5'd4, C_URS | C_URT | C_BR, 5'd7, 5'd7, M_MMR, RUN));
    // div then mflo: stalled through T+8, proceeds T+9.
    tbl.push_back(nop(3'b000, C_MD, RUN | START));
    for (int i = 0; i < 7; i++) tbl.push_back(nop(3'b000, C_HL, STL | BUSY));
    tbl.push_back(nop(3'b000, C_HL, STL | BUSY | WB));
    tbl.push_back(nop(3'b000, C_HL, RUN));
    // div, independent add, second md op blocked while busy.
    tbl.push_back(nop(3'b000, C_MD, RUN | START));
    tbl.push_back(mk(5'd1, 5'd2, C_URS | C_URT, 5'd0, 5'd0, 3'b000, RUN | BUSY));
    tbl.push_back(nop(3'b000, C_MD, STL | BUSY));
    for (int i = 0; i < 5; i++) tbl.push_back(nop(3'b000, 8'h00, RUN | BUSY));
    tbl.push_back(nop(3'b000, 8'h00, RUN | BUSY | WB));
    tbl.push_back(nop(3'b000, 8'h00, RUN));
    // Memory ack on third cycle.
    tbl.push_back(nop(M_REQ, 8'h00, FRZ));
    tbl.push_back(nop(M_REQ, 8'h00, FRZ));
    tbl.push_back(nop(M_REQ | M_ACK, 8'h00, RUN));
    // Load-use during freeze: freeze wins, no bubble.
    tbl.push_back(mk(5'd8, 5'd0, C_URS | C_EMR | C_ERW, 5'd8, 5'd0, M_REQ, FRZ));
    tbl.push_back(mk(5'd8, 5'd0, C_URS | C_EMR | C_ERW, 5'd8, 5'd0, M_REQ | M_ACK, STL));
    tbl.push_back(nop(3'b000, 8'h00, RUN));
    // md_start suppressed by freeze; md latency unaffected by later freeze.
    tbl.push_back(nop(M_REQ, C_MD, FRZ));
    tbl.push_back(nop(M_REQ | M_ACK, C_MD, RUN | START));
    for (int i = 0; i < 3; i++) tbl.push_back(nop(M_REQ, 8'h00, FRZ | BUSY));
    tbl.push_back(nop(M_REQ | M_ACK, 8'h00, RUN | BUSY));
    for (int i = 0; i < 3; i++) tbl.push_back(nop(3'b000, 8'h00, RUN | BUSY));
    tbl.push_back(nop(3'b000, 8'h00, RUN | BUSY | WB));
    tbl.push_back(nop(3'b000, 8'h00, RUN));
    // Timeout: four frozen cycles, then mem_err with freeze released.
    for (int i = 0; i < 4; i++) tbl.push_back(nop(M_REQ, 8'h00, FRZ));
    tbl.push_back(nop(M_REQ, 8'h00, RUN | ERR));
    tbl.push_back(nop(3'b000, 8'h00, RUN));

    // Reset outputs, with md op and memory request present.
    rst = 1'b1;
    exp_cnt = '0;
    drive(nop(M_REQ, C_MD | C_BR | C_BT, 9'h000));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp("reset_outputs", 32'(obs), 32'(STL));
      cmp("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    end
    @(posedge clk);
    #1;
    drive(nop(3'b000, 8'h00, 9'h000));
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
    cmp("saturated_count", 32'(stall_cycles), 32'(CNT_MAX));

    // Reset while the mul/div counter holds 3: op abandoned, no wb afterwards.
    step(nop(3'b000, C_MD, RUN | START), 1000);
    for (int i = 0; i < 3; i++) step(nop(3'b000, 8'h00, RUN | BUSY), 1001 + i);
    rst = 1'b1;
    #1;
    cmp("rst_mid_div_busy", 32'(md_busy), 32'd0);
    cmp("rst_mid_div_outputs", 32'(obs), 32'(STL));
    cmp("rst_mid_div_count", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 10; i++) step(nop(3'b000, 8'h00, RUN), 1100 + i);
    step(mk(5'd8, 5'd0, C_URS | C_EMR | C_ERW, 5'd8, 5'd0, 3'b000, STL), 1200);
    step(nop(3'b000, 8'h00, RUN), 1201);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
